dl_instr_encoder: RTL and testbench
===================================

Name: dl_instr_encoder

Overview:
- Issue-side counterpart of the DLFloat16 FPU instruction decoder.
- Accepts abstract FPU operation requests (op enum, register indices, rounding mode) over a valid/ready handshake.
- Encodes each request into the 32-bit instruction word that the decoder consumes, queues it in a small FIFO, and presents it to the FPU over a second valid/ready handshake.
- Illegal requests are dropped and counted.

Parameters:
DEPTH, 4, FIFO entries (power of 2, min 2)
FMT, 2'b10, fmt field value placed in instr[26:25]
ERRW, 8, width of the saturating error counter

Ports:
clk  in  1  clock, all state rises on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous FIFO clear, highest priority
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  5  operation code (see Behaviour)
req_rd  in  5  destination register
req_rs1  in  5  source 1
req_rs2  in  5  source 2
req_rs3  in  5  source 3 (FMA/FMS only)
req_rm  in  3  rounding mode
instr_valid  out  1  FIFO head valid
instr_ready  in  1  FPU consumes head when instr_valid & instr_ready
instr  out  32  encoded instruction at FIFO head
err_pulse  out  1  one-cycle pulse: illegal request dropped
err_count  out  ERRW  saturating count of dropped requests
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0, async): FIFO empty, pointers 0, level=0, instr_valid=0, instr=0, err_pulse=0, err_count=0.
- req_ready = (level != DEPTH). There is no same-cycle bypass when full.
- Field layout:
  - instr[31:27] = funct5 (or rs3 for FMA/FMS)
  - [26:25] = FMT
  - [24:20] = rs2
  - [19:15] = rs1
  - [14:12] = rm
  - [11:7] = rd
  - [6:0] = opcode
- Op table (req_op: funct5, rm source). Opcode is 7'b1011011 unless noted.
  - 0 ADD 00000, req_rm
  - 1 SUB 00001, req_rm
  - 2 MUL 00010, req_rm
  - 3 DIV 00011, req_rm
  - 4 SQRT 01011, req_rm, rs2 forced 0
  - 5 SGNJ 00100, rm=000
  - 6 SGNJN 00100, rm=001
  - 7 SGNJX 00100, rm=010
  - 8 MIN 00101, rm=000
  - 9 MAX 00101, rm=001
  - 10 CVT_W 01000, req_rm, rs2=0
  - 11 CVT_F 01001, req_rm, rs2=0
  - 12 FEQ 10100, rm=010
  - 13 FLT 10100, rm=001
  - 14 FLE 10100, rm=000
  - 15 FMA: opcode 7'b1000011, [31:27]=rs3, req_rm
  - 16 FMS: opcode 7'b1000111, [31:27]=rs3, req_rm
- Illegal request conditions:
  - req_op 17..31, or
  - req_rm in {3'b101, 3'b110} for an op that uses req_rm.
  - An illegal request is still accepted (handshake completes) but is not written to the FIFO.
  - err_pulse=1 on the following cycle; err_count increments and saturates at all-ones.
- Latency: a legal request accepted at edge N has instr_valid=1 by cycle N+1 if the FIFO was empty. Ordering is strictly FIFO.
- instr holds the head entry stably while instr_valid & !instr_ready; it never changes under a stalled valid.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Push into an empty FIFO while instr_ready=1: no bypass; the entry appears next cycle.
- flush=1: pointers and level go to 0 at the edge. A same-cycle request is discarded, not enqueued; err is not counted unless the request is illegal. err_count is unaffected by flush.
- Pointers wrap modulo DEPTH. A full/empty distinction is required (extra pointer bit or level counter).
- Reset mid-stream: all entries are lost and outputs return to reset values immediately.

Decomposition:
- Package dl_fpu_pkg:
  - op enum (5-bit)
  - opcode constants OPC_FP=7'b1011011, OPC_FMA=7'b1000011, OPC_FMS=7'b1000111
  - funct5 constants
  - rm legality function
- Sub-module dl_sync_fifo (DEPTH, WIDTH=32), instantiated once. The encoder logic stays in the top.

Test Plan:
- Reset, then ADD rd=1 rs1=2 rs2=3 rm=000 -> instr=0x043100DB, instr_valid at cycle N+1.
- MAX rd=5 rs1=6 rs2=7, req_rm=111 (overridden to 001) -> instr=0x2C7312DB.
- FMA rd=1 rs1=2 rs2=3 rs3=4 rm=000 -> instr=0x243100C3.
- instr_ready=0, push 5 legal ops with DEPTH=4 -> 4 accepted, req_ready=0, level=4. Then instr_ready=1 -> instructions drain in order, req_ready reasserts the cycle after the first pop.
- req_op=20, then ADD with rm=101 -> both handshakes complete, two err_pulses, err_count=2, level stays 0. With ERRW=2, 5 illegal ops -> err_count=3.
- FIFO holding 3 entries, flush=1 together with a legal req -> level=0, instr_valid=0 next cycle. Assert rst_n low mid-drain -> outputs zero asynchronously.

Source files
------------

// File: rtl/dl_fpu_pkg.sv
// Shared definitions for the DLFloat16 FPU issue path: operation codes,
// major opcodes, funct5 values and rounding-mode legality.
package dl_fpu_pkg;

  // Abstract FPU operations as presented on the request port.
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_MUL   = 5'd2,
    OP_DIV   = 5'd3,
    OP_SQRT  = 5'd4,
    OP_SGNJ  = 5'd5,
    OP_SGNJN = 5'd6,
    OP_SGNJX = 5'd7,
    OP_MIN   = 5'd8,
    OP_MAX   = 5'd9,
    OP_CVT_W = 5'd10,
    OP_CVT_F = 5'd11,
    OP_FEQ   = 5'd12,
    OP_FLT   = 5'd13,
    OP_FLE   = 5'd14,
    OP_FMA   = 5'd15,
    OP_FMS   = 5'd16
  } fpu_op_e;

  // Major opcodes understood by the decoder.
  localparam logic [6:0] OPC_FP  = 7'b1011011;
  localparam logic [6:0] OPC_FMA = 7'b1000011;
  localparam logic [6:0] OPC_FMS = 7'b1000111;

  // funct5 values for the OPC_FP group.
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SUB  = 5'b00001;
  localparam logic [4:0] F5_MUL  = 5'b00010;
  localparam logic [4:0] F5_DIV  = 5'b00011;
  localparam logic [4:0] F5_SGNJ = 5'b00100;
  localparam logic [4:0] F5_MMX  = 5'b00101;
  localparam logic [4:0] F5_CVTW = 5'b01000;
  localparam logic [4:0] F5_CVTF = 5'b01001;
  localparam logic [4:0] F5_SQRT = 5'b01011;
  localparam logic [4:0] F5_CMP  = 5'b10100;

  // Rounding modes 101 and 110 are reserved encodings.
  function automatic logic rm_legal(input logic [2:0] rm);
    return !((rm == 3'b101) || (rm == 3'b110));
  endfunction

endpackage

// File: rtl/dl_sync_fifo.sv
// Single-clock FIFO with synchronous flush. The head word is driven to zero
// whenever the FIFO is empty so the output never exposes stale storage.
module dl_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_L);
  assign valid   = (count != '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && valid && !flush;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // Storage write; contents are only observable through a valid head.
  // NOTE: the data array has no reset -- validity lives in count, so resetting
  // the memory would only add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dl_instr_encoder.sv
// Issue-side encoder: turns abstract FPU requests into 32-bit instruction
// words, queues them, and counts illegal requests that get dropped.
module dl_instr_encoder
  import dl_fpu_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [1:0] FMT   = 2'b10,
  parameter int         ERRW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_op,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [4:0]               req_rs3,
  input  logic [2:0]               req_rm,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic                     err_pulse,
  output logic [ERRW-1:0]          err_count,
  output logic [$clog2(DEPTH):0]   level
);

  logic        legal_op;
  logic        uses_rm;
  logic [4:0]  top_field;
  logic [2:0]  rm_eff;
  logic [4:0]  rs2_eff;
  logic [6:0]  opcode;
  logic [31:0] enc_word;
  logic        illegal;
  logic        accept;
  logic        fifo_full;

  // Field selection from the op table.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    legal_op  = 1'b1;
    uses_rm   = 1'b1;
    top_field = F5_ADD;
    rm_eff    = req_rm;
    rs2_eff   = req_rs2;
    opcode    = OPC_FP;
    case (req_op)
      OP_ADD:   top_field = F5_ADD;
      OP_SUB:   top_field = F5_SUB;
      OP_MUL:   top_field = F5_MUL;
      OP_DIV:   top_field = F5_DIV;
      OP_SQRT:  begin top_field = F5_SQRT; rs2_eff = '0; end
      OP_SGNJ:  begin top_field = F5_SGNJ; uses_rm = 1'b0; rm_eff = 3'b000; end
      OP_SGNJN: begin top_field = F5_SGNJ; uses_rm = 1'b0; rm_eff = 3'b001; end
      OP_SGNJX: begin top_field = F5_SGNJ; uses_rm = 1'b0; rm_eff = 3'b010; end
      OP_MIN:   begin top_field = F5_MMX;  uses_rm = 1'b0; rm_eff = 3'b000; end
      OP_MAX:   begin top_field = F5_MMX;  uses_rm = 1'b0; rm_eff = 3'b001; end
      OP_CVT_W: begin top_field = F5_CVTW; rs2_eff = '0; end
      OP_CVT_F: begin top_field = F5_CVTF; rs2_eff = '0; end
      OP_FEQ:   begin top_field = F5_CMP;  uses_rm = 1'b0; rm_eff = 3'b010; end
      OP_FLT:   begin top_field = F5_CMP;  uses_rm = 1'b0; rm_eff = 3'b001; end
      OP_FLE:   begin top_field = F5_CMP;  uses_rm = 1'b0; rm_eff = 3'b000; end
      OP_FMA:   begin top_field = req_rs3; opcode = OPC_FMA; end
      OP_FMS:   begin top_field = req_rs3; opcode = OPC_FMS; end
      default:  begin legal_op = 1'b0; uses_rm = 1'b0; end
    endcase
  end

  assign enc_word  = {top_field, FMT, rs2_eff, req_rs1, rm_eff, req_rd, opcode};
  assign illegal   = !legal_op || (uses_rm && !rm_legal(req_rm));
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;

  dl_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (accept && !illegal),
    .wdata (enc_word),
    .pop   (instr_ready),
    .full  (fifo_full),
    .valid (instr_valid),
    .rdata (instr),
    .count (level)
  );

  // Dropped-request reporting: one-cycle pulse plus a saturating counter
  // that flush leaves alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= accept && illegal;
      if (accept && illegal && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dl_instr_encoder.sv
// Self-checking bench for dl_instr_encoder: directed cases from the op table
// plus randomized traffic against a queue-based reference model.
module tb_dl_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op, req_rd, req_rs1, req_rs2, req_rs3;
  logic [2:0]  req_rm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [2:0]  level;

  // Second instance with a 2-bit error counter to exercise saturation.
  logic        b_req_ready, b_instr_valid, b_err_pulse;
  logic [31:0] b_instr;
  logic [1:0]  b_err_count;
  logic [2:0]  b_level;

  always #5 clk = ~clk;

  dl_instr_encoder #(.DEPTH(DEPTH), .FMT(2'b10), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_rm(req_rm), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .err_pulse(err_pulse), .err_count(err_count), .level(level)
  );

  dl_instr_encoder #(.DEPTH(DEPTH), .FMT(2'b10), .ERRW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_rm(req_rm), .instr_valid(b_instr_valid), .instr_ready(instr_ready),
    .instr(b_instr), .err_pulse(b_err_pulse), .err_count(b_err_count), .level(b_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] q[$];
  int          m_errs;
  logic        m_pulse;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Op table as written: funct5, fixed rm (-1 = use req_rm), rs2 zeroed.
  function automatic bit ref_illegal(input int op, input int rm);
    bit takes_rm;
    if (op > 16) return 1'b1;
    takes_rm = (op <= 4) || (op == 10) || (op == 11) || (op >= 15);
    return takes_rm && (rm == 5 || rm == 6);
  endfunction

  function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                             input int rs2, input int rs3, input int rm);
    int f5_tab [15] = '{0, 1, 2, 3, 11, 4, 4, 4, 5, 5, 8, 9, 20, 20, 20};
    int rm_tab [15] = '{-1, -1, -1, -1, -1, 0, 1, 2, 0, 1, -1, -1, 2, 1, 0};
    int top, r, s2, opc;
    if (op >= 15) begin
      top = rs3; r = rm; s2 = rs2;
      opc = (op == 15) ? 'h43 : 'h47;
    end else begin
      top = f5_tab[op];
      r   = (rm_tab[op] < 0) ? rm : rm_tab[op];
      s2  = (op == 4 || op == 10 || op == 11) ? 0 : rs2;
      opc = 'h5B;
    end
    return (top << 27) + (2 << 25) + (s2 << 20) + (rs1 << 15) + (r << 12) + (rd << 7) + opc;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".req_ready"},   32'(req_ready),   32'(q.size() != DEPTH));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(q.size() != 0));
    check({tag, ".level"},       32'(level),       32'(q.size()));
    check({tag, ".instr"},       instr,            (q.size() != 0) ? q[0] : 32'h0);
    check({tag, ".err_pulse"},   32'(err_pulse),   32'(m_pulse));
    check({tag, ".err_count"},   32'(err_count),   32'((m_errs > 255) ? 255 : m_errs));
    check({tag, ".sat_count"},   32'(b_err_count), 32'((m_errs > 3) ? 3 : m_errs));
  endtask

  // One clock: predict from current inputs, advance, compare #1 after edge.
  task automatic step(input string tag);
    bit acc, ill, pop;
    logic [31:0] w;
    acc = req_valid && (q.size() != DEPTH);
    ill = ref_illegal(int'(req_op), int'(req_rm));
    pop = instr_ready && (q.size() != 0);
    w   = ref_encode(int'(req_op), int'(req_rd), int'(req_rs1),
                     int'(req_rs2), int'(req_rs3), int'(req_rm));
    @(posedge clk);
    #1;
    m_pulse = acc && ill;
    if (acc && ill) m_errs++;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && !ill) q.push_back(w);
    end
    check_all(tag);
  endtask

  task automatic drive(input int op, input int rd, input int rs1, input int rs2,
                       input int rs3, input int rm);
    req_valid = 1'b1;
    req_op = 5'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1);
    req_rs2 = 5'(rs2); req_rs3 = 5'(rs3); req_rm = 3'(rm);
  endtask

  task automatic model_reset();
    q.delete();
    m_errs  = 0;
    m_pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
    req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rm = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed encodings with fixed golden words; each lands at N+1.
    instr_ready = 1'b1;
    drive(0, 1, 2, 3, 0, 0);  step("add");
    check("add.word", instr, 32'h043100DB);
    drive(9, 5, 6, 7, 0, 7);  step("max");
    check("max.word", instr, 32'h2C7312DB);
    drive(15, 1, 2, 3, 4, 0); step("fma");
    check("fma.word", instr, 32'h243100C3);
    req_valid = 1'b0;         step("idle");

    // Fill beyond depth with the consumer stalled, then drain.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i, i + 1, i + 2, i + 3, 0, 1);
      step("fill");
    end
    check("fill.level", 32'(level), 32'd4);
    req_valid = 1'b0;
    step("stall");
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("drain");

    // Illegal op and reserved rounding mode: accepted, counted, dropped.
    drive(20, 1, 1, 1, 1, 0);  step("ill_op");
    drive(0, 1, 2, 3, 0, 5);   step("ill_rm");
    check("ill.count", 32'(err_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(17 + i, 0, 0, 0, 0, 0);
      step("ill_sat");
    end
    check("ill.sat", 32'(b_err_count), 32'd3);
    req_valid = 1'b0;          step("ill_idle");

    // Flush with three queued entries and a concurrent legal request.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, i, i, i, 0, 2);
      step("pre_flush");
    end
    drive(2, 9, 9, 9, 0, 0);
    flush = 1'b1;              step("flush");
    flush = 1'b0; req_valid = 1'b0;
    step("post_flush");

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_op      = 5'($urandom_range(0, 19));
      req_rd      = 5'($urandom); req_rs1 = 5'($urandom);
      req_rs2     = 5'($urandom); req_rs3 = 5'($urandom);
      req_rm      = 3'($urandom);
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a drain.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3, i, 4, 5, 0, 0);
      step("pre_rst");
    end
    req_valid = 1'b0; instr_ready = 1'b1;
    step("mid_drain");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
